// File: rtl/reg_bank_4x16_loader.sv
// Loads a 4-word burst into R0..R3, then scans the downstream 4:1 mux select
// through 00..11, holding each code SCAN_HOLD cycles.
//
// state | meaning
// IDLE  | waiting for start; bank and full hold their values
// LOAD  | accepting words into R[wr_ptr] whenever in_valid is high
// SCAN  | stepping A1:A0 through 00..11 with scan_valid high
module reg_bank_4x16_loader #(
    parameter int unsigned SCAN_HOLD = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic [15:0] R0,
    output logic [15:0] R1,
    output logic [15:0] R2,
    output logic [15:0] R3,
    output logic        A0,
    output logic        A1,
    output logic        scan_valid,
    output logic        full
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(SCAN_HOLD - 1);

    state_t            state_q, state_d;
    logic [3:0][15:0]  bank_q, bank_d;
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]        sel_q, sel_d;
    logic [3:0]        hold_q, hold_d;
    logic              full_q, full_d;

    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        wr_ptr_d = wr_ptr_q;
        sel_d    = sel_q;
        hold_d   = hold_q;
        full_d   = full_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = LOAD;
                    wr_ptr_d = 2'd0;
                    full_d   = 1'b0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    bank_d[wr_ptr_q] = in_data;
                    wr_ptr_d         = wr_ptr_q + 2'd1;
                    if (wr_ptr_q == 2'd3) begin
                        state_d = SCAN;
                        full_d  = 1'b1;
                        sel_d   = 2'd0;
                        hold_d  = 4'd0;
                    end
                end
            end
            SCAN: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = 4'd0;
                    // sel wraps 11 -> 00 on the same edge that returns to IDLE
                    sel_d  = sel_q + 2'd1;
                    if (sel_q == 2'd3) begin
                        state_d = IDLE;
                    end
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            bank_q   <= '0;
            wr_ptr_q <= 2'd0;
            sel_q    <= 2'd0;
            hold_q   <= 4'd0;
            full_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bank_q   <= bank_d;
            wr_ptr_q <= wr_ptr_d;
            sel_q    <= sel_d;
            hold_q   <= hold_d;
            full_q   <= full_d;
        end
    end

    assign in_ready   = (state_q == LOAD);
    assign scan_valid = (state_q == SCAN);
    assign R0         = bank_q[0];
    assign R1         = bank_q[1];
    assign R2         = bank_q[2];
    assign R3         = bank_q[3];
    assign A0         = sel_q[0];
    assign A1         = sel_q[1];
    assign full       = full_q;

endmodule

// File: tb/tb_reg_bank_4x16_loader.sv
// Bench for reg_bank_4x16_loader: two instances (SCAN_HOLD=1 and 3) share the
// same stimulus and are checked against a scoreboard every cycle.
module tb_reg_bank_4x16_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;

    logic             in_ready1, sv1, full1, a0_1, a1_1;
    logic [3:0][15:0] r1;
    logic             in_ready3, sv3, full3, a0_3, a1_3;
    logic [3:0][15:0] r3;

    reg_bank_4x16_loader #(.SCAN_HOLD(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .R0(r1[0]), .R1(r1[1]), .R2(r1[2]), .R3(r1[3]),
        .A0(a0_1), .A1(a1_1), .scan_valid(sv1), .full(full1)
    );

    reg_bank_4x16_loader #(.SCAN_HOLD(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready3), .R0(r3[0]), .R1(r3[1]), .R2(r3[2]), .R3(r3[3]),
        .A0(a0_3), .A1(a1_3), .scan_valid(sv3), .full(full3)
    );

    // Reference model
    logic [15:0] bank_m [4];
    logic [1:0]  ptr_m;
    bit          load_m, full_m, scan1_m, scan3_m;
    int          sq1 [$];
    int          sq3 [$];
    logic [17:0] wq [$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int e1, e3;
        scan1_m = (sq1.size() > 0);
        scan3_m = (sq3.size() > 0);
        e1 = scan1_m ? sq1.pop_front() : 0;
        e3 = scan3_m ? sq3.pop_front() : 0;
        chk("scan_valid_h1", 32'(sv1), 32'(scan1_m));
        chk("scan_valid_h3", 32'(sv3), 32'(scan3_m));
        chk("sel_h1", 32'({a1_1, a0_1}), e1);
        chk("sel_h3", 32'({a1_3, a0_3}), e3);
        chk("in_ready_h1", 32'(in_ready1), 32'(load_m));
        chk("in_ready_h3", 32'(in_ready3), 32'(load_m));
        chk("full_h1", 32'(full1), 32'(full_m));
        chk("full_h3", 32'(full3), 32'(full_m));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("R%0d_h1", i), 32'(r1[i]), 32'(bank_m[i]));
            chk($sformatf("R%0d_h3", i), 32'(r3[i]), 32'(bank_m[i]));
        end
    endtask

    task automatic do_cycle(input bit v, input logic [15:0] d, input bit st);
        bit          acc, go;
        logic [17:0] w;
        reset    = 1'b0;
        in_valid = v;
        in_data  = d;
        start    = st;
        acc = v && load_m;
        go  = st && !load_m && !scan1_m && !scan3_m;
        if (acc) wq.push_back({ptr_m, d});
        @(posedge clk);
        #1;
        if (acc) begin
            w = wq.pop_front();
            bank_m[w[17:16]] = w[15:0];
            chk("wr_h1", 32'(r1[w[17:16]]), 32'(w[15:0]));
            chk("wr_h3", 32'(r3[w[17:16]]), 32'(w[15:0]));
            if (ptr_m == 2'd3) begin
                load_m = 1'b0;
                full_m = 1'b1;
                for (int k = 0; k < 4; k++) sq1.push_back(k);
                for (int k = 0; k < 12; k++) sq3.push_back(k / 3);
            end
            ptr_m = ptr_m + 2'd1;
        end
        if (go) begin
            load_m = 1'b1;
            full_m = 1'b0;
            ptr_m  = 2'd0;
        end
        check_state();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) bank_m[i] = 16'h0000;
        ptr_m  = 2'd0;
        load_m = 1'b0;
        full_m = 1'b0;
        sq1.delete();
        sq3.delete();
        wq.delete();
        check_state();
    endtask

    task automatic idle(input int n);
        repeat (n) do_cycle(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic burst(input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2, input logic [15:0] w3);
        do_cycle(1'b0, 16'h0000, 1'b1);
        do_cycle(1'b1, w0, 1'b0);
        do_cycle(1'b1, w1, 1'b0);
        do_cycle(1'b1, w2, 1'b0);
        do_cycle(1'b1, w3, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) bank_m[i] = 16'h0000;
        ptr_m = 2'd0; load_m = 1'b0; full_m = 1'b0; scan1_m = 1'b0; scan3_m = 1'b0;

        // reset with start/in_valid also high
        do_reset();
        do_reset();

        // basic burst; a valid word offered during SCAN must be ignored
        burst(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        do_cycle(1'b1, 16'hDEAD, 1'b0);
        idle(12);

        // second burst pattern (SCAN_HOLD=3 instance holds each code 3 cycles)
        burst(16'hABCD, 16'h0001, 16'h8000, 16'hFFFF);
        idle(13);

        // in_valid toggling 1,0,0,1,1,0,1
        do_cycle(1'b0, 16'h0000, 1'b1);
        do_cycle(1'b1, 16'h1001, 1'b0);
        do_cycle(1'b0, 16'hBAD0, 1'b0);
        do_cycle(1'b0, 16'hBAD1, 1'b0);
        do_cycle(1'b1, 16'h1002, 1'b0);
        do_cycle(1'b1, 16'h1003, 1'b0);
        do_cycle(1'b0, 16'hBAD2, 1'b0);
        do_cycle(1'b1, 16'h1004, 1'b0);
        idle(13);

        // start pulses during LOAD and SCAN, including the SCAN->IDLE edge of the hold=1 unit
        do_cycle(1'b0, 16'h0000, 1'b1);
        do_cycle(1'b1, 16'h7001, 1'b0);
        do_cycle(1'b1, 16'h7002, 1'b0);
        do_cycle(1'b0, 16'h0000, 1'b1);
        do_cycle(1'b1, 16'h7003, 1'b1);
        do_cycle(1'b1, 16'h7004, 1'b0);
        do_cycle(1'b0, 16'h0000, 1'b1);
        idle(2);
        do_cycle(1'b0, 16'h0000, 1'b1);
        idle(9);

        // burst from IDLE with full=1: full drops on LOAD entry
        burst(16'h0000, 16'h0000, 16'h0000, 16'h0001);
        idle(13);

        // reset during SCAN
        burst(16'h0F0F, 16'hF0F0, 16'h5A5A, 16'hA5A5);
        do_cycle(1'b0, 16'h0000, 1'b0);
        do_reset();

        // reset after two accepted words
        do_cycle(1'b0, 16'h0000, 1'b1);
        do_cycle(1'b1, 16'hAAAA, 1'b0);
        do_cycle(1'b1, 16'h5555, 1'b0);
        do_reset();
        idle(1);

        // recovery burst after reset
        burst(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        idle(13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
